// File: rtl/sha256_ctrl_pkg.sv
// Shared state encoding and block-geometry constants for the SHA-256 round controller.
package sha256_ctrl_pkg;

   localparam int NUM_ROUNDS   = 64;
   localparam int MSG_WORDS    = 16;
   localparam int DIGEST_WORDS = 8;
   localparam int LOAD_CYCLES  = 17;
   localparam int SCHED_SWITCH = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      FINAL,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/sha256_step_counter.sv
// Phase step counter: cleared while its phase is inactive, counts while enabled, flags the terminal value.
module sha256_step_counter #(
   parameter int WIDTH = 6,
   parameter int TERM  = 63
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   output logic [WIDTH-1:0] count_nxt,
   output logic             at_term
);

   logic [WIDTH-1:0] count;

   always_comb begin
      count_nxt = count;
      if (clear) begin
         count_nxt = '0;
      end else if (en) begin
         count_nxt = count + WIDTH'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   assign at_term = (count == WIDTH'(TERM));

endmodule

// File: rtl/sha256_round_controller.sv
// Sequencer for one SHA-256 block: load 16 words, 64 rounds, hash add, 8 digest writes.
// Optional SHA256_CTRL_PERF_EN adds block-count and last-block-latency outputs.
module sha256_round_controller #(
   parameter int NUM_ROUNDS = 64,
   parameter int MSG_WORDS  = 16,
   parameter int ADDR_W     = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              first_block,
   input  logic              abort,
   input  logic [ADDR_W-1:0] msg_base,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              load_word_en,
   output logic [3:0]        word_idx,
   output logic              hash_init,
   output logic              round_en,
   output logic [5:0]        round_idx,
   output logic              sched_sel,
   output logic              hash_add_en,
   output logic              out_wr_en,
   output logic [2:0]        out_addr,
   output logic              busy,
   output logic              done
`ifdef SHA256_CTRL_PERF_EN
   ,
   output logic [15:0]       perf_blocks,
   output logic [7:0]        perf_last_cycles
`endif
);

   import sha256_ctrl_pkg::*;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] base_nxt;
   logic [4:0]        ld_nxt;
   logic              ld_last;
   logic [5:0]        rnd_nxt;
   logic              rnd_last;
   logic [2:0]        wr_nxt;
   logic              wr_last;

   sha256_step_counter #(.WIDTH(5), .TERM(LOAD_CYCLES - 1)) u_load_cnt (
      .clock     (clock),
      .reset     (reset),
      .clear     (state != LOAD),
      .en        (1'b1),
      .count_nxt (ld_nxt),
      .at_term   (ld_last)
   );

   sha256_step_counter #(.WIDTH(6), .TERM(NUM_ROUNDS - 1)) u_round_cnt (
      .clock     (clock),
      .reset     (reset),
      .clear     (state != ROUND),
      .en        (1'b1),
      .count_nxt (rnd_nxt),
      .at_term   (rnd_last)
   );

   sha256_step_counter #(.WIDTH(3), .TERM(DIGEST_WORDS - 1)) u_write_cnt (
      .clock     (clock),
      .reset     (reset),
      .clear     (state != WRITE),
      .en        (1'b1),
      .count_nxt (wr_nxt),
      .at_term   (wr_last)
   );

   // Abort overrides every transition, including a start seen in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)    state_nxt = LOAD;
         LOAD:    if (ld_last)  state_nxt = ROUND;
         ROUND:   if (rnd_last) state_nxt = FINAL;
         FINAL:                 state_nxt = WRITE;
         WRITE:   if (wr_last)  state_nxt = DONE;
         DONE:                  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
      end
   end

   assign base_nxt = (state == IDLE) ? msg_base : base_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      base_q <= base_nxt;
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_rd_en    <= 1'b0;
         mem_rd_addr  <= '0;
         load_word_en <= 1'b0;
         word_idx     <= '0;
         hash_init    <= 1'b0;
         round_en     <= 1'b0;
         round_idx    <= '0;
         sched_sel    <= 1'b0;
         hash_add_en  <= 1'b0;
         out_wr_en    <= 1'b0;
         out_addr     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         mem_rd_en    <= 1'b0;
         load_word_en <= 1'b0;
         hash_init    <= 1'b0;
         round_en     <= 1'b0;
         hash_add_en  <= 1'b0;
         out_wr_en    <= 1'b0;
         done         <= 1'b0;
         busy         <= (state_nxt != IDLE);
         case (state_nxt)
            LOAD: begin
               hash_init <= (state == IDLE) && first_block;
               if (ld_nxt < 5'(MSG_WORDS)) begin
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= base_nxt + ADDR_W'(ld_nxt);
               end
               if (ld_nxt != 5'd0) begin
                  load_word_en <= 1'b1;
                  word_idx     <= 4'(ld_nxt - 5'd1);
               end
            end
            ROUND: begin
               round_en  <= 1'b1;
               round_idx <= rnd_nxt;
               sched_sel <= (rnd_nxt >= 6'(SCHED_SWITCH));
            end
            FINAL: hash_add_en <= 1'b1;
            WRITE: begin
               out_wr_en <= 1'b1;
               out_addr  <= wr_nxt;
            end
            DONE: done <= 1'b1;
            default: ;
         endcase
      end
   end

`ifdef SHA256_CTRL_PERF_EN
   logic [7:0] run_cnt;

   // run_cnt equals the cycle number since the accepting start edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_cnt          <= '0;
         perf_blocks      <= '0;
         perf_last_cycles <= '0;
      end else begin
         if (state == IDLE) begin
            run_cnt <= 8'd1;
         end else begin
            run_cnt <= run_cnt + 8'd1;
         end
         if (state_nxt == DONE) begin
            perf_last_cycles <= run_cnt + 8'd1;
            if (perf_blocks != 16'hFFFF) begin
               perf_blocks <= perf_blocks + 16'd1;
            end
         end
      end
   end
`endif

endmodule
